countdown_timer_99: RTL and testbench
=====================================

// Module: countdown_timer_99
// PURPOSE
//  Loadable two-digit down counter for the digital timer: counts a preset (0..MAX_COUNT)
//  down to 0 at one step per prescaled tick, then flags expiry. Counterpart of the
//  mod-100 up counter; feeds the same 7-seg/BCD display path and the alarm logic.
// PARAMETERS
//  MAX_COUNT    99  largest accepted preset; larger load_value saturates to MAX_COUNT
//  TICK_DIV     4   clk cycles per count step (>=1; 1 = step every RUNNING cycle)
//  AUTO_RELOAD  0   1: on expiry reload last preset and keep RUNNING
// PORTS
//  clk         in   1  rising-edge clock
//  reset       in   1  synchronous, active-low reset
//  clear       in   1  abort; count->0, state IDLE
//  load        in   1  latch load_value as preset and count
//  load_value  in   8  binary preset
//  start       in   1  begin/resume countdown
//  pause       in   1  hold countdown, keep count and prescaler phase
//  count       out  8  current binary value
//  bcd_tens    out  4  count/10
//  bcd_ones    out  4  count%10
//  running     out  1  high in RUNNING
//  expired     out  1  high in EXPIRED (level)
//  done        out  1  one-cycle pulse on each 1->0 step (also under AUTO_RELOAD)
// BEHAVIOUR
//  - All outputs registered. reset low at posedge: state IDLE, count=0, preset=0,
//    prescaler=0, running=0, expired=0, done=0. Reset overrides everything, any state.
//  - States: IDLE, LOADED, RUNNING, PAUSED, EXPIRED. Per-cycle control priority:
//    clear > load > start > pause.
//  - clear: any state -> IDLE, count=0, prescaler=0.
//  - load: any state -> LOADED; count=preset=min(load_value,MAX_COUNT); prescaler=0;
//    done=0. Load during RUNNING aborts the run.
//  - start: LOADED/PAUSED -> RUNNING. In LOADED with count==0: -> EXPIRED next cycle
//    with done pulse (no tick wait). Ignored in IDLE, RUNNING, EXPIRED.
//  - pause: RUNNING -> PAUSED, prescaler frozen; resume continues the same phase.
//    Ignored elsewhere.
//  - RUNNING: prescaler increments each cycle; at TICK_DIV-1 it wraps to 0 and a tick
//    fires. On tick, count decrements (visible next cycle). Tick with count==1:
//    count=0, done=1 for one cycle; AUTO_RELOAD=0 -> EXPIRED, running=0, expired=1;
//    AUTO_RELOAD=1 -> count=preset on the following tick, stays RUNNING.
//  - Latency: start asserted at edge N -> first decrement visible after edge
//    N+TICK_DIV.
//  - pause and tick in same cycle: pause wins, no decrement.
//  - EXPIRED holds count=0 until clear or load. Never underflows or wraps past 0.
//  - AUTO_RELOAD with preset 0: start -> EXPIRED as above (no zero-length loop).
//  - bcd_tens/bcd_ones registered alongside count, always consistent with it.
// STRUCTURE
//  - Package timer_pkg: state enum/localparams (ST_IDLE..ST_EXPIRED, 3 bits),
//    COUNT_W=8, BCD_W=4.
//  - Sub-module tick_prescaler (clk, reset, en, clr -> tick): cycle divider with hold.
//  - Top: FSM, count/preset registers, binary-to-BCD (0..99) conversion.
// TESTING (bench: TICK_DIV=4, MAX_COUNT=99)
//  - reset low 2 cycles mid-run -> count=0, state IDLE, running=0, expired=0, done=0.
//  - load 5, start -> count 4,3,2,1,0 every 4 cycles; done one cycle at 1->0;
//    expired=1; bcd 0/5 at load.
//  - load 150 -> count=99, bcd_tens=9, bcd_ones=9; load 0 + start -> EXPIRED next
//    cycle, done=1.
//  - load 10, start, pause after 6 cycles (count 9), hold 20 cycles -> count stays 9;
//    start -> next decrement 2 cycles later.
//  - clear+load+start same cycle -> IDLE, count 0; load+start same cycle -> LOADED.
//  - AUTO_RELOAD=1, load 2, start -> 1,0 (done), 2,1,0 (done) ..., running stays 1.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and widths for the two-digit countdown timer.
package timer_pkg;
   localparam int COUNT_W = 8;
   localparam int BCD_W   = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOADED  = 3'd1,
      ST_RUNNING = 3'd2,
      ST_PAUSED  = 3'd3,
      ST_EXPIRED = 3'd4
   } state_t;
endpackage

// File: rtl/countdown_timer_99_if.sv
// Control and display bundle between the timer front panel and the countdown core.
interface countdown_timer_99_if;
   import timer_pkg::*;

   logic               clear;
   logic               load;
   logic [COUNT_W-1:0] load_value;
   logic               start;
   logic               pause;
   logic [COUNT_W-1:0] count;
   logic [BCD_W-1:0]   bcd_tens;
   logic [BCD_W-1:0]   bcd_ones;
   logic               running;
   logic               expired;
   logic               done;

   modport master (
      output clear, load, load_value, start, pause,
      input  count, bcd_tens, bcd_ones, running, expired, done
   );

   modport slave (
      input  clear, load, load_value, start, pause,
      output count, bcd_tens, bcd_ones, running, expired, done
   );
endinterface

// File: rtl/tick_prescaler.sv
// Cycle divider: one tick every TICK_DIV enabled cycles; phase holds while en is low.
module tick_prescaler #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int PH_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PH_W-1:0] LAST = PH_W'(TICK_DIV - 1);

   logic [PH_W-1:0] phase;

   assign tick = en && (phase == LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         phase <= '0;
      end else if (clr) begin
         phase <= '0;
      end else if (en) begin
         phase <= (phase == LAST) ? '0 : phase + 1'b1;
      end
   end
endmodule

// File: rtl/countdown_timer_99.sv
// Loadable two-digit down counter with pause, expiry flag and optional auto-reload.
module countdown_timer_99
   import timer_pkg::*;
#(
   parameter int MAX_COUNT   = 99,
   parameter int TICK_DIV    = 4,
   parameter int AUTO_RELOAD = 0
) (
   input logic              clk,
   input logic              reset,
   countdown_timer_99_if.slave bus
);
   localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

   state_t             state;
   logic [COUNT_W-1:0] preset;
   logic               tick;
   logic               presc_en;
   logic               presc_clr;

   function automatic logic [COUNT_W-1:0] sat_preset(input logic [COUNT_W-1:0] v);
      return (v > MAX_C) ? MAX_C : v;
   endfunction

   function automatic logic [2*BCD_W-1:0] to_bcd(input logic [COUNT_W-1:0] v);
      return {BCD_W'(v / COUNT_W'(10)), BCD_W'(v % COUNT_W'(10))};
   endfunction

   // The prescaler only advances in cycles where the run actually continues.
   assign presc_clr = bus.clear || bus.load;
   assign presc_en  = (state == ST_RUNNING) && !bus.clear && !bus.load && !bus.pause;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk   (clk),
      .reset (reset),
      .en    (presc_en),
      .clr   (presc_clr),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state                        <= ST_IDLE;
         preset                       <= '0;
         bus.count                    <= '0;
         {bus.bcd_tens, bus.bcd_ones} <= '0;
         bus.running                  <= 1'b0;
         bus.expired                  <= 1'b0;
         bus.done                     <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (bus.clear) begin
            state                        <= ST_IDLE;
            bus.count                    <= '0;
            {bus.bcd_tens, bus.bcd_ones} <= '0;
            bus.running                  <= 1'b0;
            bus.expired                  <= 1'b0;
         end else if (bus.load) begin
            state                        <= ST_LOADED;
            preset                       <= sat_preset(bus.load_value);
            bus.count                    <= sat_preset(bus.load_value);
            {bus.bcd_tens, bus.bcd_ones} <= to_bcd(sat_preset(bus.load_value));
            bus.running                  <= 1'b0;
            bus.expired                  <= 1'b0;
         end else if (bus.start && (state == ST_LOADED || state == ST_PAUSED)) begin
            // A zero preset expires immediately instead of entering a zero-length run.
            if (state == ST_LOADED && bus.count == '0) begin
               state       <= ST_EXPIRED;
               bus.done    <= 1'b1;
               bus.expired <= 1'b1;
               bus.running <= 1'b0;
            end else begin
               state       <= ST_RUNNING;
               bus.running <= 1'b1;
            end
         end else if (bus.pause && state == ST_RUNNING) begin
            state       <= ST_PAUSED;
            bus.running <= 1'b0;
         end else if (tick) begin
            if (bus.count == COUNT_W'(1)) begin
               bus.count                    <= '0;
               {bus.bcd_tens, bus.bcd_ones} <= '0;
               bus.done                     <= 1'b1;
               if (AUTO_RELOAD == 0) begin
                  state       <= ST_EXPIRED;
                  bus.running <= 1'b0;
                  bus.expired <= 1'b1;
               end
            end else if (bus.count == '0) begin
               // Only reachable with auto-reload: restart from the last preset.
               bus.count                    <= preset;
               {bus.bcd_tens, bus.bcd_ones} <= to_bcd(preset);
            end else begin
               bus.count                    <= bus.count - 1'b1;
               {bus.bcd_tens, bus.bcd_ones} <= to_bcd(bus.count - 1'b1);
            end
         end
      end
   end
endmodule

// File: tb/tb_countdown_timer_99.sv
// Scoreboard bench for countdown_timer_99: one plain instance and one auto-reload instance.
module tb_countdown_timer_99;
   import timer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   countdown_timer_99_if ifa ();
   countdown_timer_99_if ifb ();

   countdown_timer_99 #(.MAX_COUNT(99), .TICK_DIV(4), .AUTO_RELOAD(0)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   countdown_timer_99 #(.MAX_COUNT(99), .TICK_DIV(4), .AUTO_RELOAD(1)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   typedef struct {
      int   cyc;
      int   dut;
      int   cnt;
      bit   run;
      bit   ex;
      bit   dn;
   } exp_t;

   exp_t  q[$];
   string qn[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   exp_t  mon_e;
   string mon_nm;

   task automatic push(input int off, input int dut, input int cnt,
                       input bit run, input bit ex, input bit dn, input string nm);
      exp_t e;
      e.cyc = cyc + off;
      e.dut = dut;
      e.cnt = cnt;
      e.run = run;
      e.ex  = ex;
      e.dn  = dn;
      q.push_back(e);
      qn.push_back(nm);
   endtask

   task automatic chk(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s.%s: got %0d expected %0d (cycle %0d)", nm, fld, act, req, cyc);
      end
   endtask

   task automatic cmp_all(input string nm, input exp_t e, input logic [7:0] cnt,
                          input logic [3:0] tens, input logic [3:0] ones,
                          input logic run, input logic ex, input logic dn);
      chk(nm, "count",    32'(cnt),  32'(e.cnt));
      chk(nm, "bcd_tens", 32'(tens), 32'(e.cnt / 10));
      chk(nm, "bcd_ones", 32'(ones), 32'(e.cnt % 10));
      chk(nm, "running",  32'(run),  32'(e.run));
      chk(nm, "expired",  32'(ex),   32'(e.ex));
      chk(nm, "done",     32'(dn),   32'(e.dn));
   endtask

   // Monitor: compares every expectation whose cycle has arrived.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         mon_e  = q.pop_front();
         mon_nm = qn.pop_front();
         if (mon_e.cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: slot cycle %0d missed at cycle %0d", mon_nm, mon_e.cyc, cyc);
         end else if (mon_e.dut == 0) begin
            cmp_all(mon_nm, mon_e, ifa.count, ifa.bcd_tens, ifa.bcd_ones,
                    ifa.running, ifa.expired, ifa.done);
         end else begin
            cmp_all(mon_nm, mon_e, ifb.count, ifb.bcd_tens, ifb.bcd_ones,
                    ifb.running, ifb.expired, ifb.done);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, %0d expectations pending", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      ifa.clear = 0; ifa.load = 0; ifa.start = 0; ifa.pause = 0; ifa.load_value = '0;
      ifb.clear = 0; ifb.load = 0; ifb.start = 0; ifb.pause = 0; ifb.load_value = '0;
      step(3);
      push(0, 0, 0, 0, 0, 0, "rst_a");
      push(0, 1, 0, 0, 0, 0, "rst_b");
      reset = 1'b1;
      step(1);

      // load 5, count down to expiry
      ifa.load = 1; ifa.load_value = 8'd5;
      step(1);
      ifa.load = 0;
      push(0, 0, 5, 0, 0, 0, "load5");
      ifa.start = 1;
      step(1);
      ifa.start = 0;
      push(0,  0, 5, 1, 0, 0, "run5_start");
      push(4,  0, 4, 1, 0, 0, "run5_4");
      push(8,  0, 3, 1, 0, 0, "run5_3");
      push(12, 0, 2, 1, 0, 0, "run5_2");
      push(16, 0, 1, 1, 0, 0, "run5_1");
      push(19, 0, 1, 1, 0, 0, "run5_1_late");
      push(20, 0, 0, 0, 1, 1, "run5_expire");
      push(21, 0, 0, 0, 1, 0, "run5_done_drop");
      push(30, 0, 0, 0, 1, 0, "run5_hold");
      step(31);

      // reset mid-run
      ifa.load = 1; ifa.load_value = 8'd8;
      step(1);
      ifa.load = 0; ifa.start = 1;
      step(1);
      ifa.start = 0;
      step(5);
      push(0, 0, 7, 1, 0, 0, "pre_rst");
      reset = 1'b0;
      step(1);
      push(0, 0, 0, 0, 0, 0, "rst_mid1");
      step(1);
      push(0, 0, 0, 0, 0, 0, "rst_mid2");
      reset = 1'b1;
      ifa.start = 1;
      step(1);
      ifa.start = 0;
      push(0, 0, 0, 0, 0, 0, "start_idle");
      step(1);

      // saturation and zero preset
      ifa.load = 1; ifa.load_value = 8'd150;
      step(1);
      push(0, 0, 99, 0, 0, 0, "load150");
      ifa.load_value = 8'd0;
      step(1);
      ifa.load = 0;
      push(0, 0, 0, 0, 0, 0, "load0");
      ifa.start = 1;
      step(1);
      ifa.start = 0;
      push(0, 0, 0, 0, 1, 1, "start0_expire");
      step(1);
      push(0, 0, 0, 0, 1, 0, "start0_hold");
      step(1);

      // pause and resume keep prescaler phase
      ifa.load = 1; ifa.load_value = 8'd10;
      step(1);
      ifa.load = 0; ifa.start = 1;
      step(1);
      ifa.start = 0;
      push(0, 0, 10, 1, 0, 0, "p_start");
      push(4, 0, 9,  1, 0, 0, "p_first");
      push(6, 0, 9,  1, 0, 0, "p_before");
      step(6);
      ifa.pause = 1;
      step(1);
      ifa.pause = 0;
      push(0, 0, 9, 0, 0, 0, "paused");
      step(20);
      push(0, 0, 9, 0, 0, 0, "pause_hold");
      ifa.start = 1;
      step(1);
      ifa.start = 0;
      push(0, 0, 9, 1, 0, 0, "resume");
      push(1, 0, 9, 1, 0, 0, "resume_1");
      push(2, 0, 8, 1, 0, 0, "resume_dec");
      step(3);

      // control priority
      ifa.clear = 1; ifa.load = 1; ifa.start = 1; ifa.load_value = 8'd7;
      step(1);
      ifa.clear = 0;
      push(0, 0, 0, 0, 0, 0, "clr_ld_st");
      step(1);
      ifa.load = 0; ifa.start = 0;
      push(0, 0, 7, 0, 0, 0, "ld_st");
      ifa.start = 1;
      step(1);
      ifa.start = 0;
      push(0, 0, 7, 1, 0, 0, "start_loaded");
      ifa.clear = 1;
      step(1);
      ifa.clear = 0;
      push(0, 0, 0, 0, 0, 0, "clear_run");
      step(1);

      // auto-reload instance
      ifb.load = 1; ifb.load_value = 8'd2;
      step(1);
      ifb.load = 0;
      push(0, 1, 2, 0, 0, 0, "ar_load2");
      ifb.start = 1;
      step(1);
      ifb.start = 0;
      push(0,  1, 2, 1, 0, 0, "ar_start");
      push(4,  1, 1, 1, 0, 0, "ar_1a");
      push(8,  1, 0, 1, 0, 1, "ar_0a");
      push(9,  1, 0, 1, 0, 0, "ar_0a_drop");
      push(12, 1, 2, 1, 0, 0, "ar_reload");
      push(16, 1, 1, 1, 0, 0, "ar_1b");
      push(20, 1, 0, 1, 0, 1, "ar_0b");
      push(21, 1, 0, 1, 0, 0, "ar_0b_drop");
      push(24, 1, 2, 1, 0, 0, "ar_reload2");
      step(26);

      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL leftover: got %0d pending expectations, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
